// File: rtl/registrador_id_ex_pkg.sv
// Shared definitions for the ID/EX buffer: ALU op codes, skid-buffer state and payload width.
package pacote_ula;

    localparam logic [1:0] NAO     = 2'd0;
    localparam logic [1:0] SOMA    = 2'd1;
    localparam logic [1:0] SUBTRAI = 2'd2;

    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        UM    = 2'd1,
        DOIS  = 2'd2
    } estado_skid_t;

    // Payload layout, MSB first: dina, dinb, imm, soma_ou_subtrai, usa_imm, rd
    function automatic int largura_payload(input int bits, input int reg_bits);
        return 3 * bits + 2 + 1 + reg_bits;
    endfunction

endpackage

// File: rtl/registrador_carga.sv
// Load-enabled register of generic width with asynchronous active-low clear.
module registrador_carga #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            carga,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (carga) begin
            q <= d;
        end
    end

endmodule

// File: rtl/registrador_id_ex.sv
// Decode->execute 2-entry skid buffer feeding the ALU over valid/ready.
// Optional stall counter enabled by defining ID_EX_CONTADOR_STALL_EN.
module registrador_id_ex
    import pacote_ula::*;
#(
    parameter int BITS     = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_dina,
    input  logic [BITS-1:0]     in_dinb,
    input  logic [BITS-1:0]     in_imm,
    input  logic [1:0]          in_soma_ou_subtrai,
    input  logic                in_usa_imm,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     out_dina,
    output logic [BITS-1:0]     out_dinb,
    output logic [BITS-1:0]     out_imm,
    output logic [1:0]          out_soma_ou_subtrai,
    output logic                out_usa_imm,
`ifdef ID_EX_CONTADOR_STALL_EN
    output logic [REG_BITS-1:0] out_rd,
    output logic [31:0]         stall_count
`else
    output logic [REG_BITS-1:0] out_rd
`endif
);

    localparam int W = largura_payload(BITS, REG_BITS);

    estado_skid_t estado, prox_estado;
    logic         aceita, emite, vld_p1;
    logic         carga_cab, carga_skid, cab_do_skid;
    logic [W-1:0] entrada_p0, d_cab_p0, cab_p1, skid_p1;

    assign entrada_p0 = {in_dina, in_dinb, in_imm, in_soma_ou_subtrai, in_usa_imm, in_rd};

    assign in_ready = (estado != DOIS);
    assign vld_p1   = (estado != VAZIO);
    assign aceita   = in_valid && in_ready;
    assign emite    = vld_p1 && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= VAZIO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        carga_cab   = 1'b0;
        carga_skid  = 1'b0;
        cab_do_skid = 1'b0;
        case (estado)
            VAZIO: begin
                if (aceita) begin
                    prox_estado = UM;
                    carga_cab   = 1'b1;
                end
            end
            UM: begin
                if (aceita && emite) begin
                    carga_cab = 1'b1;
                end else if (aceita) begin
                    prox_estado = DOIS;
                    carga_skid  = 1'b1;
                end else if (emite) begin
                    prox_estado = VAZIO;
                end
            end
            DOIS: begin
                if (emite) begin
                    prox_estado = UM;
                    carga_cab   = 1'b1;
                    cab_do_skid = 1'b1;
                end
            end
            default: prox_estado = VAZIO;
        endcase
        // Flush wins over everything; the bundle offered this cycle is dropped
        if (flush) begin
            prox_estado = VAZIO;
            carga_cab   = 1'b0;
            carga_skid  = 1'b0;
        end
    end

    assign d_cab_p0 = cab_do_skid ? skid_p1 : entrada_p0;

    // ---- stage p0 -> p1: head and skid payload registers ----
    registrador_carga #(.BITS(W)) u_cabeca (
        .clk   (clk),
        .rst_n (rst_n),
        .carga (carga_cab),
        .d     (d_cab_p0),
        .q     (cab_p1)
    );

    registrador_carga #(.BITS(W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .carga (carga_skid),
        .d     (entrada_p0),
        .q     (skid_p1)
    );

    assign out_valid = vld_p1;
    assign {out_dina, out_dinb, out_imm, out_soma_ou_subtrai, out_usa_imm, out_rd} = cab_p1;

`ifdef ID_EX_CONTADOR_STALL_EN
    function automatic logic [31:0] incrementa_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (vld_p1 && !out_ready) begin
            stall_count <= incrementa_sat(stall_count);
        end
    end
`endif

endmodule

// File: tb/tb_registrador_id_ex.sv
// Randomized and directed bench for registrador_id_ex against a queue-based FIFO model.
module tb_registrador_id_ex;
    import pacote_ula::*;

    localparam int BITS     = 64;
    localparam int REG_BITS = 5;

    typedef struct packed {
        logic [BITS-1:0]     dina;
        logic [BITS-1:0]     dinb;
        logic [BITS-1:0]     imm;
        logic [1:0]          op;
        logic                usa;
        logic [REG_BITS-1:0] rd;
    } pacote_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid, in_ready, flush, out_valid, out_ready;
    logic [BITS-1:0]     in_dina, in_dinb, in_imm, out_dina, out_dinb, out_imm;
    logic [1:0]          in_soma_ou_subtrai, out_soma_ou_subtrai;
    logic                in_usa_imm, out_usa_imm;
    logic [REG_BITS-1:0] in_rd, out_rd;
`ifdef ID_EX_CONTADOR_STALL_EN
    logic [31:0]         stall_count;
`endif

    pacote_t     fila[$];
    longint      stall_mod = 0;
    int          n_vet = 0;
    int          n_err = 0;

    registrador_id_ex #(.BITS(BITS), .REG_BITS(REG_BITS)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_dina             (in_dina),
        .in_dinb             (in_dinb),
        .in_imm              (in_imm),
        .in_soma_ou_subtrai  (in_soma_ou_subtrai),
        .in_usa_imm          (in_usa_imm),
        .in_rd               (in_rd),
        .flush               (flush),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_dina            (out_dina),
        .out_dinb            (out_dinb),
        .out_imm             (out_imm),
        .out_soma_ou_subtrai (out_soma_ou_subtrai),
        .out_usa_imm         (out_usa_imm),
`ifdef ID_EX_CONTADOR_STALL_EN
        .out_rd              (out_rd),
        .stall_count         (stall_count)
`else
        .out_rd              (out_rd)
`endif
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_vet++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, esp);
        end
    endtask

    function automatic pacote_t aleatorio(input logic [REG_BITS-1:0] rd);
        pacote_t p;
        p.dina = {$urandom, $urandom};
        p.dinb = {$urandom, $urandom};
        p.imm  = {$urandom, $urandom};
        p.op   = 2'($urandom_range(0, 3));
        p.usa  = 1'($urandom_range(0, 1));
        p.rd   = rd;
        return p;
    endfunction

    task automatic confere(input string tag);
        verifica({tag, ".out_valid"}, 64'(out_valid), 64'(fila.size() > 0));
        verifica({tag, ".in_ready"}, 64'(in_ready), 64'(fila.size() < 2));
        if (fila.size() > 0) begin
            verifica({tag, ".dina"}, out_dina, fila[0].dina);
            verifica({tag, ".dinb"}, out_dinb, fila[0].dinb);
            verifica({tag, ".imm"}, out_imm, fila[0].imm);
            verifica({tag, ".op"}, 64'(out_soma_ou_subtrai), 64'(fila[0].op));
            verifica({tag, ".usa"}, 64'(out_usa_imm), 64'(fila[0].usa));
            verifica({tag, ".rd"}, 64'(out_rd), 64'(fila[0].rd));
        end
`ifdef ID_EX_CONTADOR_STALL_EN
        verifica({tag, ".stall"}, 64'(stall_count), 64'(stall_mod));
`endif
    endtask

    // One clock: drive, predict from the model's pre-edge occupancy, then compare
    task automatic aplica(input string tag, input logic v, input pacote_t p,
                          input logic ordy, input logic fl);
        logic aceita, emite;
        in_valid           = v;
        in_dina            = p.dina;
        in_dinb            = p.dinb;
        in_imm             = p.imm;
        in_soma_ou_subtrai = p.op;
        in_usa_imm         = p.usa;
        in_rd              = p.rd;
        out_ready          = ordy;
        flush              = fl;
        aceita = v && (fila.size() < 2);
        emite  = (fila.size() > 0) && ordy;
        if (fila.size() > 0 && !ordy && stall_mod < 64'hFFFF_FFFF) stall_mod++;
        @(posedge clk);
        #1;
        if (fl) begin
            fila.delete();
        end else begin
            if (emite) void'(fila.pop_front());
            if (aceita) fila.push_back(p);
        end
        confere(tag);
    endtask

    task automatic checa_zero(input string tag);
        verifica({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        verifica({tag, ".dina"}, out_dina, 64'd0);
        verifica({tag, ".dinb"}, out_dinb, 64'd0);
        verifica({tag, ".imm"}, out_imm, 64'd0);
        verifica({tag, ".oprd"}, 64'({out_soma_ou_subtrai, out_usa_imm, out_rd}), 64'd0);
`ifdef ID_EX_CONTADOR_STALL_EN
        verifica({tag, ".stall"}, 64'(stall_count), 64'd0);
`endif
    endtask

    initial begin
        pacote_t p, a, b, c;
        rst_n = 1'b0;
        in_valid = 0; in_dina = 0; in_dinb = 0; in_imm = 0;
        in_soma_ou_subtrai = 0; in_usa_imm = 0; in_rd = 0;
        flush = 0; out_ready = 0;
        #12;
        checa_zero("reset");
        verifica("reset.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Single bundle after reset
        p = '0; p.dina = 64'd5; p.dinb = 64'd3; p.op = SUBTRAI; p.rd = 5'd7;
        aplica("single", 1'b1, p, 1'b1, 1'b0);
        aplica("single_drain", 1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A, B fill; C blocked, then held until accepted
        a = aleatorio(5'd1); b = aleatorio(5'd2); c = aleatorio(5'd3);
        aplica("bp_a", 1'b1, a, 1'b0, 1'b0);
        aplica("bp_b", 1'b1, b, 1'b0, 1'b0);
        aplica("bp_c_blocked", 1'b1, c, 1'b0, 1'b0);
        aplica("bp_c_blocked2", 1'b1, c, 1'b0, 1'b0);
        aplica("bp_release", 1'b1, c, 1'b1, 1'b0);
        aplica("bp_c_in", 1'b1, c, 1'b1, 1'b0);
        aplica("bp_drain1", 1'b0, '0, 1'b1, 1'b0);
        aplica("bp_drain2", 1'b0, '0, 1'b1, 1'b0);

        // Streaming rd 0..7 at full rate
        for (int i = 0; i < 8; i++) aplica("stream", 1'b1, aleatorio(5'(i)), 1'b1, 1'b0);
        aplica("stream_tail", 1'b0, '0, 1'b1, 1'b0);

        // Flush with full buffer and incoming bundle
        aplica("fl_fill1", 1'b1, aleatorio(5'd4), 1'b0, 1'b0);
        aplica("fl_fill2", 1'b1, aleatorio(5'd5), 1'b0, 1'b0);
        aplica("flush", 1'b1, aleatorio(5'd9), 1'b0, 1'b1);
        aplica("post_flush", 1'b0, '0, 1'b1, 1'b0);

`ifdef ID_EX_CONTADOR_STALL_EN
        // Stall counter: 10 stalled cycles, then a flush must not clear it
        rst_n = 1'b0; #1; rst_n = 1'b1; fila.delete(); stall_mod = 0;
        aplica("st_push", 1'b1, aleatorio(5'd6), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) aplica("st_hold", 1'b0, '0, 1'b0, 1'b0);
        verifica("stall_ten", 64'(stall_count), 64'd10);
        aplica("st_flush", 1'b0, '0, 1'b0, 1'b1);
        verifica("stall_after_flush", 64'(stall_count), 64'd11);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            aplica("rand", 1'($urandom_range(0, 3) != 0), aleatorio(5'($urandom)),
                   1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset between edges while full
        aplica("ar_fill1", 1'b1, aleatorio(5'd10), 1'b0, 1'b0);
        aplica("ar_fill2", 1'b1, aleatorio(5'd11), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        fila.delete();
        stall_mod = 0;
        checa_zero("async_reset");
        verifica("async_reset.in_ready", 64'(in_ready), 64'd1);
        // No capture while reset is held across an edge
        in_valid = 1'b1;
        @(posedge clk); #1;
        checa_zero("reset_held");
        rst_n = 1'b1;
        aplica("after_reset", 1'b1, aleatorio(5'd12), 1'b1, 1'b0);
        aplica("after_reset_drain", 1'b0, '0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/registrador_id_ex.md
Name: registrador_id_ex

Overview:
Decode→execute pipeline buffer that sits directly upstream of the ALU (ULA). It captures the operand/control bundle: dina, dinb, imm, soma_ou_subtrai, usa_imm and destination register. It presents that bundle to the ALU through a valid/ready handshake. The storage is a 2-entry skid buffer, so a registered in_ready still never drops or duplicates an instruction. A synchronous flush squashes in-flight entries on branch redirect.

Parameters:
BITS, 64, operand width (dina/dinb/imm)
REG_BITS, 5, destination register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream bundle valid
in_ready  output  1  buffer can accept (state != DOIS)
in_dina  input  BITS  operand A
in_dinb  input  BITS  operand B
in_imm  input  BITS  immediate
in_soma_ou_subtrai  input  2  ALU op: 0 nao, 1 soma, 2 subtrai (3 reserved, passed through)
in_usa_imm  input  1  select imm as ALU operand B
in_rd  input  REG_BITS  destination register
flush  input  1  synchronous squash
out_valid  output  1  head entry valid
out_ready  input  1  ALU/execute accepts head
out_dina, out_dinb, out_imm  output  BITS  head operands
out_soma_ou_subtrai  output  2  head ALU op
out_usa_imm  output  1  head imm select
out_rd  output  REG_BITS  head destination

Behaviour:
- Transfers: accept = in_valid && in_ready; issue = out_valid && out_ready. Both are evaluated on the same rising edge.
- State machine, registered, encoded in the package:
  - VAZIO: 0 entries. accept → UM.
  - UM: 1 entry. accept && !issue → DOIS. issue && !accept → VAZIO. Both or neither → UM (on both, head replaced by incoming).
  - DOIS: 2 entries. issue → UM (skid entry moves to head). Otherwise stays DOIS.
- in_ready = (state != DOIS). It depends only on registered state, never on out_ready.
- out_valid = (state != VAZIO). Out_* always reflect the head register; no combinational path from in_* to out_*.
- Latency: 1 cycle from accept to out_valid when empty. Strict FIFO order is preserved.
- Throughput: 1 bundle/cycle while out_ready is held high.
- Head/skid data are held stable while out_valid && !out_ready.
- in_valid while in_ready=0: no capture. Upstream must hold the bundle.
- flush: next state VAZIO, regardless of accept/issue that cycle.
  - A bundle presented on the flush cycle is dropped, not captured.
  - An issue on the flush cycle still counts as consumed by the ALU.
- Reset (rst_n=0, asynchronous):
  - state=VAZIO, out_valid=0, in_ready=1 after release.
  - All out_* data = 0 and skid register = 0.
  - Reset mid-transfer discards all entries. No accept takes effect while rst_n=0.
- Payload fields are opaque: no arithmetic, no width change. soma_ou_subtrai=3 is passed unchanged.

Optional Feature:
ID_EX_CONTADOR_STALL_EN
- Defined:
  - Adds output stall_count (32 bits), reset 0.
  - Increments each cycle with out_valid && !out_ready. Saturates at 0xFFFF_FFFF.
  - Unaffected by flush; cleared only by rst_n.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package pacote_ula holds:
  - ALU op constants NAO=2'd0, SOMA=2'd1, SUBTRAI=2'd2.
  - Skid state typedef {VAZIO, UM, DOIS}.
  - Packed payload struct/width constant: 3*BITS+2+1+REG_BITS.
- One natural sub-module: registrador_carga, a BITS-generic load-enabled register with async active-low reset. It is instantiated for the head and skid payload registers.

Test Plan:
1. Reset then single bundle: rst_n 0→1, in_valid=1, dina=5, dinb=3, op=SUBTRAI, rd=7, out_ready=1. Required: out_valid next cycle with out_dina=5, out_dinb=3, out_soma_ou_subtrai=2, out_rd=7. in_ready stays 1.
2. Backpressure fill: out_ready=0, push A(rd=1) and B(rd=2) on consecutive cycles. Required: in_ready=0 after B; a third bundle C is not captured. Raise out_ready: order A, B, then C once accepted.
3. Streaming: out_ready=1, 8 back-to-back bundles rd=0..7. Required: 8 consecutive out_valid cycles, rd 0..7 in order, in_ready constantly 1.
4. Flush with full buffer plus incoming: state DOIS, flush=1 and in_valid=1 (rd=9). Required: next cycle out_valid=0, in_ready=1; rd=9 never appears.
5. Async reset mid-stall: state DOIS, pull rst_n low between clock edges. Required: out_valid=0 and out_* data=0 immediately, without waiting for a clock edge.
6. With ID_EX_CONTADOR_STALL_EN: hold out_valid=1, out_ready=0 for 10 cycles. Required: stall_count=10. A flush does not clear it.
